// File: rtl/ibex_fetch_ring_fifo_if.sv
// Fetch FIFO bus: instruction-side words in, aligned instructions out to ID.
// The FIFO takes the slave view; the fetch/ID side takes the master view.
interface ibex_fetch_ring_fifo_if;
  logic        in_valid_i;
  logic [31:0] in_addr_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_addr_o;
  logic [31:0] out_rdata_o;
  logic        out_err_o;
  logic        out_err_plus2_o;
  logic        out_compressed_o;

  modport slave (
    input  in_valid_i, in_addr_i, in_rdata_i, in_err_i,
    input  out_ready_i,
    output out_valid_o, out_addr_o, out_rdata_o,
    output out_err_o, out_err_plus2_o, out_compressed_o
  );

  modport master (
    output in_valid_i, in_addr_i, in_rdata_i, in_err_i,
    output out_ready_i,
    input  out_valid_o, out_addr_o, out_rdata_o,
    input  out_err_o, out_err_plus2_o, out_compressed_o
  );
endinterface

// File: rtl/ibex_fetch_ring_fifo.sv
// Ring-buffer fetch FIFO with 16/32-bit realignment and PC tracking.
// Define FETCH_FIFO_BYPASS_EN to feed an empty FIFO's output straight from the bus.
module ibex_fetch_ring_fifo #(
  parameter int unsigned  NUM_REQS = 2,
  parameter bit           ResetAll = 1'b0,
  localparam int unsigned DEPTH    = NUM_REQS + 1,
  localparam int unsigned LW       = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  output logic [NUM_REQS-1:0] busy_o,
  output logic [LW-1:0]       level_o,
  ibex_fetch_ring_fifo_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nx;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [31:1]   pc_q, pc_d;

  entry_t h, n;
  logic   h_vld, n_vld, byp, n_err;
  logic   comp, valid, err, plus2;
  logic [31:0] rdata;
  logic   accept, pop, push, pop_m, push_m, full;
  logic   unused_addr0;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_nx = inc(rd_q);
  assign unused_addr0 = bus.in_addr_i[0];

`ifdef FETCH_FIFO_BYPASS_EN
  always_comb begin
    byp   = (cnt_q == '0) & bus.in_valid_i;
    h     = byp ? {bus.in_err_i, bus.in_rdata_i} : mem_q[rd_q];
    h_vld = (cnt_q != '0) | bus.in_valid_i;
    n     = (cnt_q >= LW'(2)) ? mem_q[rd_nx]
                              : {bus.in_err_i, bus.in_rdata_i};
    n_vld = (cnt_q >= LW'(2)) |
            ((cnt_q == LW'(1)) & bus.in_valid_i);
  end
`else
  always_comb begin
    byp   = 1'b0;
    h     = mem_q[rd_q];
    h_vld = (cnt_q != '0);
    n     = mem_q[rd_nx];
    n_vld = (cnt_q >= LW'(2));
  end
`endif

  // Odd half-word PC: instruction starts in the upper half of H.
  always_comb begin
    n_err = n_vld & n.err;
    rdata = h.data;
    valid = h_vld;
    err   = h.err;
    plus2 = 1'b0;
    comp  = (h.data[1:0] != 2'b11) & ~h.err;
    if (pc_q[1]) begin
      comp  = (h.data[17:16] != 2'b11) & ~h.err;
      rdata = {n.data[15:0], h.data[31:16]};
      valid = h_vld & (comp | h.err | n_vld);
      err   = h.err | (~comp & n_err);
      plus2 = ~h.err & ~comp & n_err;
    end
  end

  assign accept = valid & bus.out_ready_i & ~clear_i;
  assign pop    = accept & (pc_q[1] | ~comp);
  assign full   = (cnt_q == LW'(DEPTH));
  assign push   = bus.in_valid_i & ~clear_i & (~full | pop);
  // A bypassed word consumed in its arrival cycle never enters storage.
  assign pop_m  = pop & ~byp;
  assign push_m = push & ~(byp & pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    pc_d  = pc_q;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      pc_d  = bus.in_addr_i[31:1];
    end else begin
      if (pop_m)  rd_d = rd_nx;
      if (push_m) wr_d = inc(wr_q);
      if (push_m & ~pop_m)      cnt_d = cnt_q + LW'(1);
      else if (pop_m & ~push_m) cnt_d = cnt_q - LW'(1);
      if (accept) pc_d = pc_q + (comp ? 31'd1 : 31'd2);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      pc_q  <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
    end
  end

  if (ResetAll) begin : g_mem_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_m) begin
        mem_q[wr_q] <= {bus.in_err_i, bus.in_rdata_i};
      end
    end
  end else begin : g_mem_nrst
    always_ff @(posedge clk_i) begin
      if (push_m) mem_q[wr_q] <= {bus.in_err_i, bus.in_rdata_i};
    end
  end

  for (genvar j = 0; j < NUM_REQS; j++) begin : g_busy
    assign busy_o[j] = (cnt_q >= LW'(j + 2));
  end

  assign level_o              = cnt_q;
  assign bus.out_valid_o      = valid;
  assign bus.out_addr_o       = {pc_q, 1'b0};
  assign bus.out_rdata_o      = rdata;
  assign bus.out_err_o        = err;
  assign bus.out_err_plus2_o  = plus2;
  assign bus.out_compressed_o = comp;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.in_valid_i & ~clear_i & full & ~pop));

endmodule

// File: tb/tb_ibex_fetch_ring_fifo.sv
// Bench for ibex_fetch_ring_fifo: vector table plus scoreboard of
// expected instructions, with hand-written sequences for corner cases.
module tb_ibex_fetch_ring_fifo;
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [NR-1:0] busy;
  logic [2:0]    lvl;

  ibex_fetch_ring_fifo_if bus();

  ibex_fetch_ring_fifo #(.NUM_REQS(NR), .ResetAll(1'b0)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(clr),
    .busy_o (busy),
    .level_o(lvl),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  chk;
    logic        comp;
    logic        err;
    logic        plus2;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w0;
    logic        e0;
    logic [31:0] w1;
    logic        e1;
    logic [1:0]  nw;
    logic [1:0]  nx;
    exp_t        x0;
    exp_t        x1;
    exp_t        x2;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  vec_t vec[4];

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] r,
                              input logic [1:0] c, input logic cp,
                              input logic er, input logic p2);
    exp_t e;
    e.addr = a; e.rdata = r; e.chk = c;
    e.comp = cp; e.err = er; e.plus2 = p2;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon();
    exp_t        e;
    logic [31:0] m;
    if (bus.out_valid_o && bus.out_ready_i && !clr) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h @%h expected none",
                 bus.out_rdata_o, bus.out_addr_o);
      end else begin
        e = q.pop_front();
        chk("out_addr", bus.out_addr_o, e.addr);
        chk("out_comp", 32'(bus.out_compressed_o), 32'(e.comp));
        chk("out_err", 32'(bus.out_err_o), 32'(e.err));
        chk("out_plus2", 32'(bus.out_err_plus2_o), 32'(e.plus2));
        m = (e.chk == 2'd2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        if (e.chk != 2'd0)
          chk("out_rdata", bus.out_rdata_o & m, e.rdata & m);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic e,
                       input logic rdy, input logic c, input logic [31:0] a);
    @(negedge clk);
    bus.in_valid_i  = v;
    bus.in_rdata_i  = w;
    bus.in_err_i    = e;
    bus.out_ready_i = rdy;
    bus.in_addr_i   = a;
    clr             = c;
    if (c) q.delete();
    #1;
    mon();
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 1'b0, rdy, 1'b0, 32'h0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n && !(q.size() == 0 && lvl == 3'd0); k++)
      idle(1'b1);
    chk("drain_q", q.size(), 0);
    chk("drain_lvl", 32'(lvl), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [31:0] w;

    vec[0] = '{addr: 32'h80, w0: 32'h00B5_0533, e0: 1'b0,
               w1: 32'h4501_4505, e1: 1'b0, nw: 2'd2, nx: 2'd3,
               x0: mk(32'h80, 32'h00B5_0533, 2'd2, 1'b0, 1'b0, 1'b0),
               x1: mk(32'h84, 32'h0000_4505, 2'd1, 1'b1, 1'b0, 1'b0),
               x2: mk(32'h86, 32'h0000_4501, 2'd1, 1'b1, 1'b0, 1'b0)};
    vec[1] = '{addr: 32'h102, w0: 32'h0513_0001, e0: 1'b0,
               w1: 32'h0000_00B5, e1: 1'b0, nw: 2'd2, nx: 2'd2,
               x0: mk(32'h102, 32'h00B5_0513, 2'd2, 1'b0, 1'b0, 1'b0),
               x1: mk(32'h106, 32'h0000_0000, 2'd1, 1'b1, 1'b0, 1'b0),
               x2: '0};
    vec[2] = '{addr: 32'h202, w0: 32'h0513_0001, e0: 1'b0,
               w1: 32'h0000_00B5, e1: 1'b1, nw: 2'd2, nx: 2'd2,
               x0: mk(32'h202, 32'h00B5_0513, 2'd2, 1'b0, 1'b1, 1'b1),
               x1: mk(32'h206, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0),
               x2: '0};
    vec[3] = '{addr: 32'h302, w0: 32'h0513_0001, e0: 1'b1,
               w1: 32'h0, e1: 1'b0, nw: 2'd1, nx: 2'd1,
               x0: mk(32'h302, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0),
               x1: '0, x2: '0};

    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_rdata_i = '0;
    bus.in_err_i = 1'b0;
    bus.in_addr_i = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_lvl", 32'(lvl), 0);
    chk("rst_valid", 32'(bus.out_valid_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", bus.out_addr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, vec[i].addr);
      idle(1'b0);
      chk("clr_lvl", 32'(lvl), 0);
      chk("clr_valid", 32'(bus.out_valid_o), 0);
      chk("clr_addr", bus.out_addr_o, vec[i].addr);
      drive(1'b1, vec[i].w0, vec[i].e0, 1'b0, 1'b0, 32'h0);
      if (vec[i].nw == 2'd2)
        drive(1'b1, vec[i].w1, vec[i].e1, 1'b0, 1'b0, 32'h0);
      if (vec[i].nx > 2'd0) q.push_back(vec[i].x0);
      if (vec[i].nx > 2'd1) q.push_back(vec[i].x1);
      if (vec[i].nx > 2'd2) q.push_back(vec[i].x2);
      idle(1'b0);
      chk("fill_lvl", 32'(lvl), 32'(vec[i].nw));
      drain(20);
    end

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h400);
    for (int k = 0; k < 4; k++) begin
      w = 32'hA000_0003 + 32'(k) * 32'h100;
      drive(1'b1, w, 1'b0, 1'b0, 1'b0, 32'h0);
      q.push_back(mk(32'h400 + 32'(k) * 4, w, 2'd2, 1'b0, 1'b0, 1'b0));
      idle(1'b0);
      chk("full_lvl", 32'(lvl), 32'(k + 1));
      chk("full_busy", 32'(busy), (32'd1 << k) - 1);
    end
    drain(20);
    for (int k = 0; k < 6; k++) begin
      w = 32'hB000_0003 + 32'(k) * 32'h100;
      q.push_back(mk(32'h410 + 32'(k) * 4, w, 2'd2, 1'b0, 1'b0, 1'b0));
      drive(1'b1, w, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    drain(20);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h600);
    drive(1'b1, 32'h1111_0003, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h2222_0003, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    chk("pre_clr_lvl", 32'(lvl), 2);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'h700);
    idle(1'b0);
    chk("clr_pri_lvl", 32'(lvl), 0);
    chk("clr_pri_valid", 32'(bus.out_valid_o), 0);
    chk("clr_pri_addr", bus.out_addr_o, 32'h700);
    idle(1'b0);
    chk("clr_drop_lvl", 32'(lvl), 0);

    w = 32'h1234_5677;
    e = mk(32'h700, w, 2'd2, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_FIFO_BYPASS_EN
    q.push_back(e);
    drive(1'b1, w, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("byp_valid", 32'(bus.out_valid_o), 1);
`else
    drive(1'b1, w, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("lat_valid", 32'(bus.out_valid_o), 0);
    q.push_back(e);
`endif
    drain(10);

    drive(1'b1, 32'h3333_0003, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    chk("mid_lvl", 32'(lvl), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_lvl", 32'(lvl), 0);
    chk("async_valid", 32'(bus.out_valid_o), 0);
    chk("async_addr", bus.out_addr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    chk("post_rst_lvl", 32'(lvl), 0);

    chk("final_q", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
